// File: rtl/iob_wishbone2iob_pkg.sv
// Shared definitions for the Wishbone-to-IOb bridge: FSM state encoding.
package iob_wishbone2iob_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/iob_reg.sv
// Enabled register with asynchronous active-high reset, used for the bridge payload.
module iob_reg #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = en_i ? d_i : data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge; one transfer in flight, timeout -> wb_err_o.
module iob_wishbone2iob
    import iob_wishbone2iob_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic [DATA_W/8-1:0] sel_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ready_i
);

    localparam int unsigned           STRB_W  = DATA_W / 8;
    localparam logic [TIMEOUT_W-1:0]  CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0]  CNT_ONE = TIMEOUT_W'(1);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 abort_q, abort_d;
    logic                 valid_q, valid_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 capture;
    logic                 rdata_en;
    logic                 aborting;
    logic [STRB_W-1:0]    wstrb_in;

    assign wstrb_in = wb_we_i ? wb_sel_i : '0;

    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        valid_d  = valid_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        capture  = 1'b0;
        rdata_en = 1'b0;
        aborting = abort_q | ~wb_cyc_i;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                abort_d = aborting;
                if (ready_i) begin
                    // A dropped cycle still lets the IOb side finish, but the master hears nothing.
                    valid_d  = 1'b0;
                    rdata_en = ~aborting & (wstrb_o == '0);
                    ack_d    = ~aborting;
                    abort_d  = 1'b0;
                    state_d  = aborting ? ST_IDLE : ST_ACK;
                end else if (cnt_q == CNT_MAX) begin
                    valid_d = 1'b0;
                    err_d   = ~aborting;
                    abort_d = 1'b0;
                    state_d = aborting ? ST_IDLE : ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign valid_o  = valid_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

    iob_reg #(.W(ADDR_W)) u_addr_reg (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(capture), .d_i(wb_adr_i), .q_o(addr_o)
    );

    iob_reg #(.W(DATA_W)) u_wdata_reg (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(capture), .d_i(wb_dat_i), .q_o(wdata_o)
    );

    iob_reg #(.W(STRB_W)) u_wstrb_reg (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(capture), .d_i(wstrb_in), .q_o(wstrb_o)
    );

    iob_reg #(.W(STRB_W)) u_sel_reg (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(capture), .d_i(wb_sel_i), .q_o(sel_o)
    );

    iob_reg #(.W(DATA_W)) u_rdata_reg (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(rdata_en), .d_i(rdata_i), .q_o(wb_dat_o)
    );

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Scoreboard bench: Wishbone master stimulus, IOb slave model with memory, response monitor.
module tb_iob_wishbone2iob;

    localparam int TW         = 3;
    localparam int TMO_CYCLES = 8;  // a transfer may spend at most 2**TW cycles in flight

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        valid_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic [3:0]  sel_o;
    logic [31:0] rdata_i = '0;
    logic        ready_i = 1'b0;

    iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .sel_o(sel_o), .rdata_i(rdata_i), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  sel;
        int          dly;
    } ioreq_t;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
    } resp_t;

    ioreq_t      ioq[$];
    resp_t       respq[$];
    bit [31:0]   ref_mem   [bit [31:0]];
    bit [31:0]   slave_mem [bit [31:0]];
    logic [31:0] last_rdata = '0;
    int          checks = 0;
    int          errors = 0;
    int          iob_xfers = 0;
    int          last_valid_cycles = 0;
    resp_t       mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] dat,
                                        input bit [3:0] strb);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

    // Reference model: a transfer completes iff ready arrives within TMO_CYCLES in-flight cycles.
    task automatic model_issue(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                               input logic we, input int dly, input bit answered);
        ioreq_t q;
        resp_t  r;
        bit     completes;
        completes = (dly < TMO_CYCLES);
        q.addr  = adr;
        q.wdata = dat;
        q.wstrb = we ? sel : 4'h0;
        q.sel   = sel;
        q.dly   = dly;
        ioq.push_back(q);
        if (we && completes) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
        if (answered) begin
            r.is_err = !completes;
            if (!we && completes) last_rdata = ref_mem[adr];
            r.rdata = last_rdata;
            respq.push_back(r);
        end
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    // Called just after a rising edge with the bridge idle; returns just after a rising edge.
    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input int dly, input bit keep, output int lat);
        bit got;
        model_issue(adr, dat, sel, we, dly, 1'b1);
        drive_req(adr, dat, sel, we);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge clk_i);
            if (wb_ack_o || wb_err_o) begin
                got = 1'b1;
                lat = n;
            end
        end
        if (!got) check("xfer_response_seen", 0, 1);
        @(posedge clk_i);
        #1;
        if (!keep) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
    endtask

    // Master drops the cycle in the second in-flight cycle; dly must be >= 1.
    task automatic abort_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic we, input int dly);
        bit seen;
        model_issue(adr, dat, sel, we, dly, 1'b0);
        drive_req(adr, dat, sel, we);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_i);
            seen = valid_o;
        end
        if (!seen) check("abort_valid_seen", 0, 1);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            seen = !valid_o;
        end
        if (!seen) check("abort_valid_dropped", 0, 1);
        @(posedge clk_i);
        #1;
        check("abort_dat_unchanged", wb_dat_o, last_rdata);
    endtask

    // Wishbone response monitor.
    always @(negedge clk_i) begin
        if (!arst_i && (wb_ack_o || wb_err_o)) begin
            check("ack_err_exclusive", wb_ack_o & wb_err_o, 0);
            if (respq.size() == 0) begin
                check("unexpected_response", 0, 1);
            end else begin
                mon_r = respq.pop_front();
                check("resp_is_err", wb_err_o, mon_r.is_err);
                check("resp_dat", wb_dat_o, mon_r.rdata);
            end
        end
    end

    // IOb slave: answers each request after its scheduled delay, checks payload stability.
    initial begin : iob_slave
        ioreq_t sreq;
        int     k;
        bit     stable;
        bit     done;
        forever begin
            @(negedge clk_i);
            if (!arst_i && valid_o) begin
                if (ioq.size() == 0) begin
                    check("unexpected_iob_req", 0, 1);
                    for (int n = 0; n < 20 && valid_o; n++) @(negedge clk_i);
                end else begin
                    sreq = ioq.pop_front();
                    iob_xfers++;
                    check("iob_addr", addr_o, sreq.addr);
                    check("iob_wdata", wdata_o, sreq.wdata);
                    check("iob_wstrb", wstrb_o, sreq.wstrb);
                    check("iob_sel", sel_o, sreq.sel);
                    k = 0;
                    stable = 1'b1;
                    done = 1'b0;
                    while (!done) begin
                        if (arst_i || !valid_o) begin
                            done = 1'b1;
                        end else begin
                            if (addr_o !== sreq.addr || wdata_o !== sreq.wdata ||
                                wstrb_o !== sreq.wstrb || sel_o !== sreq.sel) stable = 1'b0;
                            k++;
                            if (k - 1 == sreq.dly) begin
                                ready_i = 1'b1;
                                rdata_i = slave_mem[addr_o];
                                if (wstrb_o != 4'h0)
                                    slave_mem[addr_o] = merge(slave_mem[addr_o], wdata_o, wstrb_o);
                                @(negedge clk_i);
                                ready_i = 1'b0;
                                rdata_i = $urandom;
                                done = 1'b1;
                            end else if (k > 40) begin
                                done = 1'b1;
                            end else begin
                                @(negedge clk_i);
                            end
                        end
                    end
                    last_valid_cycles = k;
                    check("iob_payload_stable", stable, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int        lat;
        int        base;
        int        r;
        int        dly;
        logic [31:0] adr;
        bit        seen;

        for (int i = 0; i < 8; i++) begin
            ref_mem[32'h100 + 4*i]   = 32'hA500_0100 + 4*i;
            ref_mem[32'h200 + 4*i]   = 32'h5A00_0200 + 4*i;
        end
        ref_mem[32'h200] = 32'h1234_5678;
        slave_mem = ref_mem;

        #3;
        check("rst_valid", valid_o, 0);
        check("rst_ack", wb_ack_o, 0);
        check("rst_err", wb_err_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wstrb", wstrb_o, 0);
        #14 arst_i = 1'b0;
        @(posedge clk_i);
        #1;

        xfer(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, 2, 1'b0, lat);
        check("write_latency", lat, 5);
        xfer(32'h200, 32'h0, 4'h3, 1'b0, 0, 1'b0, lat);
        check("read_latency", lat, 3);

        xfer(32'h104, 32'h1111_2222, 4'hF, 1'b1, 255, 1'b0, lat);
        check("timeout_latency", lat, 10);
        check("timeout_valid_cycles", last_valid_cycles, TMO_CYCLES);
        xfer(32'h108, 32'h0, 4'hF, 1'b0, TMO_CYCLES - 1, 1'b0, lat);
        check("last_cycle_ready_latency", lat, 10);
        xfer(32'h104, 32'h0, 4'hF, 1'b0, 1, 1'b0, lat);

        abort_xfer(32'h10C, 32'hCAFE_F00D, 4'hF, 1'b1, 4);
        xfer(32'h10C, 32'h0, 4'hF, 1'b0, 0, 1'b0, lat);
        check("post_abort_latency", lat, 3);
        abort_xfer(32'h200, 32'h0, 4'hF, 1'b0, 3);
        xfer(32'h110, 32'h0, 4'hF, 1'b0, 1, 1'b0, lat);

        base = iob_xfers;
        for (int i = 0; i < 4; i++) begin
            xfer(32'h204 + 4*i, 32'h0, 4'hF, 1'b0, 0, (i < 3), lat);
            check("b2b_latency", lat, 3);
        end
        repeat (2) @(posedge clk_i);
        #1;
        check("b2b_iob_xfers", iob_xfers - base, 4);
        check("b2b_resp_drained", respq.size(), 0);

        model_issue(32'h114, 32'h7777_8888, 4'hF, 1'b1, 255, 1'b0);
        drive_req(32'h114, 32'h7777_8888, 4'hF, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_i);
            seen = valid_o;
        end
        check("rst_mid_valid_seen", seen, 1);
        repeat (2) @(negedge clk_i);
        #2;
        arst_i = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        #1;
        check("rst_mid_valid", valid_o, 0);
        check("rst_mid_addr", addr_o, 0);
        check("rst_mid_wdata", wdata_o, 0);
        check("rst_mid_ack_err", {wb_ack_o, wb_err_o}, 0);
        last_rdata = '0;
        @(negedge clk_i);
        #2 arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        xfer(32'h114, 32'h0, 4'hF, 1'b0, 1, 1'b0, lat);
        check("post_reset_latency", lat, 4);

        for (int i = 0; i < 40; i++) begin
            adr = ($urandom_range(0, 1) ? 32'h200 : 32'h100) + 4 * $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            if (r <= 5)      dly = $urandom_range(0, 3);
            else if (r == 6) dly = TMO_CYCLES - 1;
            else if (r == 7) dly = TMO_CYCLES;
            else if (r == 8) dly = 255;
            else             dly = $urandom_range(4, 6);
            if (dly >= 1 && $urandom_range(0, 7) == 0)
                abort_xfer(adr, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), dly);
            else
                xfer(adr, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), dly,
                     1'($urandom_range(0, 1)), lat);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            xfer(32'h100 + 4*i, 32'h0, 4'hF, 1'b0, 0, 1'b0, lat);
            xfer(32'h200 + 4*i, 32'h0, 4'hF, 1'b0, 0, 1'b0, lat);
        end

        repeat (5) @(posedge clk_i);
        #1;
        check("final_resp_drained", respq.size(), 0);
        check("final_iob_drained", ioq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
